// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Drain side of the synchronous byte FIFO. It pops one word at a time and
//   shifts it out on an asynchronous serial line. Frame layout: start bit,
//   data bits LSB first, an optional parity bit, then a stop bit.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//   DATA_WIDTH    data bits per frame; equals the FIFO word width
//   PARITY_EN     1 inserts a parity bit after the last data bit
//   PARITY_ODD    with PARITY_EN=1: 0 = even parity, 1 = odd parity
//
// Ports
//   clock           system clock, rising edge
//   reset           asynchronous, active-high reset
//   tx_enable       level; allows new frames to start
//   fifo_empty      FIFO empty flag
//   fifo_read_data  FIFO registered read data, valid the cycle after a pop
//   fifo_r_enable   FIFO read enable, one cycle per byte
//   tx_serial       serial line, idle high, registered
//   busy            high in every state except idle
//   frame_done      one-cycle pulse in the last cycle of the stop bit
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tx_enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  fifo_r_enable,
    output logic                  tx_serial,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                  state_q;
    logic [CntW-1:0]         cycle_cnt_q;
    logic [BitW-1:0]         bit_cnt_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [DATA_WIDTH-1:0]   shift_next;
    logic                    parity_q;
    logic                    tx_q;
    logic                    bit_end;
    logic                    start_ok;

    // Last cycle of the current serial bit.
    assign bit_end    = (cycle_cnt_q == CntLast);
    // The empty flag only matters in idle and at stop exit.
    assign start_ok   = tx_enable && !fifo_empty;
    assign shift_next = shift_q >> 1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cycle_cnt_q <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    tx_q        <= 1'b1;
                    cycle_cnt_q <= '0;
                    if (start_ok) begin
                        state_q <= StPop;
                    end
                end

                // Read enable is decoded from this state; the line stays high.
                StPop: begin
                    state_q <= StLoad;
                end

                // Read data is valid now; capture it and open the start bit.
                StLoad: begin
                    shift_q     <= fifo_read_data;
                    parity_q    <= (^fifo_read_data) ^ PARITY_ODD;
                    bit_cnt_q   <= '0;
                    cycle_cnt_q <= '0;
                    tx_q        <= 1'b0;
                    state_q     <= StStart;
                end

                StStart: begin
                    if (bit_end) begin
                        cycle_cnt_q <= '0;
                        tx_q        <= shift_q[0];
                        state_q     <= StData;
                    end else begin
                        cycle_cnt_q <= cycle_cnt_q + 1'b1;
                    end
                end

                StData: begin
                    if (bit_end) begin
                        cycle_cnt_q <= '0;
                        if (bit_cnt_q == BitLast) begin
                            bit_cnt_q <= '0;
                            if (PARITY_EN) begin
                                tx_q    <= parity_q;
                                state_q <= StParity;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= StStop;
                            end
                        end else begin
                            shift_q   <= shift_next;
                            tx_q      <= shift_next[0];
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        cycle_cnt_q <= cycle_cnt_q + 1'b1;
                    end
                end

                StParity: begin
                    if (bit_end) begin
                        cycle_cnt_q <= '0;
                        tx_q        <= 1'b1;
                        state_q     <= StStop;
                    end else begin
                        cycle_cnt_q <= cycle_cnt_q + 1'b1;
                    end
                end

                // Back-to-back frames skip idle; pop/load extend the stop bit by 2.
                StStop: begin
                    tx_q <= 1'b1;
                    if (bit_end) begin
                        cycle_cnt_q <= '0;
                        state_q     <= start_ok ? StPop : StIdle;
                    end else begin
                        cycle_cnt_q <= cycle_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q     <= StIdle;
                    cycle_cnt_q <= '0;
                    tx_q        <= 1'b1;
                end
            endcase
        end
    end

    assign tx_serial     = tx_q;
    assign fifo_r_enable = (state_q == StPop);
    assign busy          = (state_q != StIdle);
    assign frame_done    = (state_q == StStop) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
//   Directed bench for fifo_uart_tx with CLKS_PER_BIT=4. Three instances
//   share clock, reset and tx_enable: no parity, even parity, odd parity.
//   Each instance has a bench-side byte queue that stands in for the FIFO.
module tb_fifo_uart_tx;

    localparam int N = 2048;

    logic       clock;
    logic       reset;
    logic       tx_enable;
    logic       empty [3];
    logic [7:0] rdata [3];
    logic       re    [3];
    logic       tx    [3];
    logic       busy  [3];
    logic       fd    [3];

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];

    logic txh  [3][N];
    logic bsyh [3][N];
    logic fdh  [3][N];
    logic reh  [3][N];

    int n;
    int checks;
    int errors;
    int uf;

    fifo_uart_tx #(.CLKS_PER_BIT(4), .DATA_WIDTH(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
        .clock(clock), .reset(reset), .tx_enable(tx_enable), .fifo_empty(empty[0]),
        .fifo_read_data(rdata[0]), .fifo_r_enable(re[0]), .tx_serial(tx[0]),
        .busy(busy[0]), .frame_done(fd[0])
    );

    fifo_uart_tx #(.CLKS_PER_BIT(4), .DATA_WIDTH(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
        .clock(clock), .reset(reset), .tx_enable(tx_enable), .fifo_empty(empty[1]),
        .fifo_read_data(rdata[1]), .fifo_r_enable(re[1]), .tx_serial(tx[1]),
        .busy(busy[1]), .frame_done(fd[1])
    );

    fifo_uart_tx #(.CLKS_PER_BIT(4), .DATA_WIDTH(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut2 (
        .clock(clock), .reset(reset), .tx_enable(tx_enable), .fifo_empty(empty[2]),
        .fifo_read_data(rdata[2]), .fifo_r_enable(re[2]), .tx_serial(tx[2]),
        .busy(busy[2]), .frame_done(fd[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd_empty();
        empty[0] = (q0.size() == 0);
        empty[1] = (q1.size() == 0);
        empty[2] = (q2.size() == 0);
    endtask

    task automatic push(input int d, input logic [7:0] b);
        case (d)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
        upd_empty();
    endtask

    // Record this cycle's outputs, advance one clock, then serve any pop.
    task automatic cyc();
        logic re_s [3];
        for (int d = 0; d < 3; d++) begin
            if (n < N) begin
                txh[d][n]  = tx[d];
                bsyh[d][n] = busy[d];
                fdh[d][n]  = fd[d];
                reh[d][n]  = re[d];
            end
            if (re[d] === 1'b1 && empty[d]) uf++;
            re_s[d] = re[d];
        end
        @(posedge clock);
        #1;
        n++;
        if (re_s[0] === 1'b1 && q0.size() > 0) rdata[0] = q0.pop_front();
        if (re_s[1] === 1'b1 && q1.size() > 0) rdata[1] = q1.pop_front();
        if (re_s[2] === 1'b1 && q2.size() > 0) rdata[2] = q2.pop_front();
        upd_empty();
    endtask

    task automatic run_until(input int c);
        while (n < c) cyc();
    endtask

    function automatic logic at_tx(input int d, input int c);
        if (c < 0 || c >= n || c >= N) return 1'bx;
        return txh[d][c];
    endfunction

    function automatic logic at_busy(input int d, input int c);
        if (c < 0 || c >= n || c >= N) return 1'bx;
        return bsyh[d][c];
    endfunction

    function automatic logic at_fd(input int d, input int c);
        if (c < 0 || c >= n || c >= N) return 1'bx;
        return fdh[d][c];
    endfunction

    function automatic int find_pop(input int d, input int from);
        for (int c = (from < 0 ? 0 : from); c < n && c < N; c++) begin
            if (reh[d][c] === 1'b1) return c;
        end
        return -1;
    endfunction

    function automatic int count_hi(input int kind, input int d, input int from, input int to);
        int k = 0;
        for (int c = from; c < to && c < n && c < N; c++) begin
            case (kind)
                0:       if (reh[d][c] === 1'b1) k++;
                1:       if (fdh[d][c] === 1'b1) k++;
                2:       if (bsyh[d][c] !== 1'b0) k++;
                default: if (txh[d][c] !== 1'b1) k++;
            endcase
        end
        return k;
    endfunction

    // Compare a whole frame starting at pop cycle p against the expected line.
    task automatic check_frame(input int d, input int p, input logic [7:0] b, input int pe,
                               input logic pb, input string tag);
        int         len;
        int         bad;
        int         bi;
        logic       e;
        logic [7:0] dec;
        len = 2 + 4 * (10 + pe);
        bad = 0;
        for (int k = 0; k < len; k++) begin
            if (k < 2) begin
                e = 1'b1;
            end else begin
                bi = (k - 2) / 4;
                if (bi == 0)                e = 1'b0;
                else if (bi <= 8)           e = b[bi-1];
                else if (bi == 9 && pe > 0) e = pb;
                else                        e = 1'b1;
            end
            if (at_tx(d, p + k) !== e) bad++;
        end
        chk({tag, "_line"}, bad, 0);
        for (int i = 0; i < 8; i++) dec[i] = at_tx(d, p + 2 + 4 * (i + 1) + 2);
        chk({tag, "_byte"}, {24'd0, dec}, {24'd0, b});
        if (pe > 0) chk({tag, "_parity"}, {31'd0, at_tx(d, p + 40)}, {31'd0, pb});
    endtask

    initial begin
        int s, p, p1, p2, pa, pb, pc, t, r;
        n = 0; checks = 0; errors = 0; uf = 0;
        reset = 1'b0;
        tx_enable = 1'b1;
        for (int d = 0; d < 3; d++) rdata[d] = 8'h00;
        upd_empty();
        #2 reset = 1'b1;
        #1;
        chk("rst_tx", {31'd0, tx[0]}, 32'd1);
        chk("rst_busy", {31'd0, busy[0]}, 32'd0);
        chk("rst_re", {31'd0, re[0]}, 32'd0);
        chk("rst_fd", {31'd0, fd[0]}, 32'd0);
        cyc();
        cyc();
        reset = 1'b0;

        // Idle with empty FIFO and tx_enable high.
        s = n;
        run_until(s + 100);
        chk("idle_no_pop", find_pop(0, s), -1);
        chk("idle_line_high", count_hi(3, 0, s, n), 0);
        chk("idle_not_busy", count_hi(2, 0, s, n), 0);

        // Single frame 0xA5, plus 0x07 on the parity instances.
        s = n;
        push(0, 8'hA5);
        push(1, 8'h07);
        push(2, 8'h07);
        run_until(s + 60);
        p = find_pop(0, s);
        chk("a5_pop_cycle", p, s + 1);
        chk("a5_one_pop", count_hi(0, 0, s, n), 1);
        check_frame(0, p, 8'hA5, 0, 1'b0, "a5");
        chk("a5_fd_count", count_hi(1, 0, s, n), 1);
        chk("a5_fd_last", {31'd0, at_fd(0, p + 41)}, 32'd1);
        chk("a5_busy_41", {31'd0, at_busy(0, p + 41)}, 32'd1);
        chk("a5_busy_42", {31'd0, at_busy(0, p + 42)}, 32'd0);
        p1 = find_pop(1, s);
        chk("even_pop_cycle", p1, s + 1);
        check_frame(1, p1, 8'h07, 1, 1'b1, "even07");
        chk("even_busy_45", {31'd0, at_busy(1, p1 + 45)}, 32'd1);
        chk("even_busy_46", {31'd0, at_busy(1, p1 + 46)}, 32'd0);
        p2 = find_pop(2, s);
        check_frame(2, p2, 8'h07, 1, 1'b0, "odd07");
        chk("odd_busy_46", {31'd0, at_busy(2, p2 + 46)}, 32'd0);

        // Three back-to-back frames.
        s = n;
        push(0, 8'h01);
        push(0, 8'h80);
        push(0, 8'hFF);
        run_until(s + 1 + 126 + 10);
        pa = find_pop(0, s);
        chk("b2b_pop0", pa, s + 1);
        pb = find_pop(0, pa + 1);
        chk("b2b_pop1", pb, pa + 42);
        pc = find_pop(0, pb + 1);
        chk("b2b_pop2", pc, pb + 42);
        chk("b2b_no_pop3", find_pop(0, pc + 1), -1);
        check_frame(0, pa, 8'h01, 0, 1'b0, "b2b01");
        check_frame(0, pb, 8'h80, 0, 1'b0, "b2b80");
        check_frame(0, pc, 8'hFF, 0, 1'b0, "b2bff");
        chk("b2b_empty", {31'd0, empty[0]}, 32'd1);

        // Drop tx_enable during the first of two queued frames.
        s = n;
        push(0, 8'h96);
        push(0, 8'h4B);
        run_until(s + 11);
        tx_enable = 1'b0;
        run_until(s + 71);
        p = find_pop(0, s);
        chk("en_pop_cycle", p, s + 1);
        check_frame(0, p, 8'h96, 0, 1'b0, "en96");
        chk("en_fd", {31'd0, at_fd(0, p + 41)}, 32'd1);
        chk("en_held", find_pop(0, p + 1), -1);
        chk("en_idle", {31'd0, at_busy(0, n - 1)}, 32'd0);
        t = n;
        tx_enable = 1'b1;
        run_until(t + 50);
        p2 = find_pop(0, p + 1);
        chk("en_resume_pop", p2, t + 1);
        check_frame(0, p2, 8'h4B, 0, 1'b0, "en4b");

        // Reset in the middle of 0x3C's data bit 0, then send 0x5A.
        s = n;
        push(0, 8'h3C);
        run_until(s + 1 + 7);
        p = find_pop(0, s);
        chk("rst3c_pop", p, s + 1);
        chk("rst3c_line_low", {31'd0, tx[0]}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst3c_line_high", {31'd0, tx[0]}, 32'd1);
        chk("rst3c_busy", {31'd0, busy[0]}, 32'd0);
        push(0, 8'h5A);
        cyc();
        cyc();
        reset = 1'b0;
        r = n;
        run_until(r + 50);
        p = find_pop(0, r);
        chk("rst5a_pop", p, r + 1);
        check_frame(0, p, 8'h5A, 0, 1'b0, "rst5a");
        chk("rst5a_empty", {31'd0, empty[0]}, 32'd1);

        chk("no_underflow", uf, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
